// File: rtl/posi_satd_cost_accum.sv
// SATD cost accumulator: |coef| sums per beat, per-sub-block normalisation, per-block cost.
// Latency: last beat accepted in cycle T -> cost_val_o pulses in cycle T+2.
// Backpressure: none; every val_i beat is accepted (clear_i drops a coincident beat).
module posi_satd_cost_accum #(
  parameter int COEF_WIDTH = 15,
  parameter int COST_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              size_i,
  input  logic                    clear_i,
  input  logic                    val_i,
  input  logic [COEF_WIDTH*8-1:0] dat_i,
  output logic                    cost_val_o,
  output logic [COST_WIDTH-1:0]   cost_o
);

  localparam logic [1:0] SIZE_04 = 2'd0;
  localparam logic [1:0] SIZE_08 = 2'd1;
  localparam logic [1:0] SIZE_16 = 2'd2;
  localparam logic [1:0] SIZE_32 = 2'd3;

  // One beat sums 8 magnitudes; one 8x8 sub-block sums 8 beats.
  localparam int SUM_W = COEF_WIDTH + 3;
  localparam int SUB_W = COEF_WIDTH + 6;

  // Beat counter and latched block size
  logic [6:0]             cnt_q, cnt_d;
  logic [1:0]             size_q, size_d;
  // Stage A registers
  logic                   a_vld_q, a_vld_d;
  logic [SUM_W-1:0]       a_sum_q, a_sum_d;
  logic                   a_sub_end_q, a_sub_end_d;
  logic                   a_blk_end_q, a_blk_end_d;
  logic                   a_half_q, a_half_d;
  // Stage B registers
  logic [SUB_W-1:0]       sub_acc_q, sub_acc_d;
  logic [COST_WIDTH-1:0]  blk_acc_q, blk_acc_d;
  logic                   cost_val_q, cost_val_d;
  logic [COST_WIDTH-1:0]  cost_q, cost_d;

  // Combinational helpers
  logic [COEF_WIDTH-1:0]  mag [8];
  logic [SUM_W-1:0]       beat_sum;
  logic                   accept;
  logic [1:0]             size_eff;
  logic [6:0]             last_idx;
  logic                   sub_end;
  logic                   blk_end;
  logic [SUB_W-1:0]       sub_sum;
  logic [SUB_W:0]         sub_rnd;
  logic [COST_WIDTH-1:0]  sub_norm;
  logic [COST_WIDTH-1:0]  blk_sum;

  // Magnitude as an unsigned COEF_WIDTH value, so the most negative code maps to 2^(COEF_WIDTH-1).
  for (genvar k = 0; k < 8; k++) begin : g_mag
    logic [COEF_WIDTH-1:0] coef;
    assign coef   = dat_i[(7-k)*COEF_WIDTH +: COEF_WIDTH];
    assign mag[k] = coef[COEF_WIDTH-1] ? (~coef + 1'b1) : coef;
  end

  // Sum of the eight lane magnitudes for the incoming beat.
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < 8; k++) begin
      beat_sum = beat_sum + SUM_W'(mag[k]);
    end
  end

  // Block framing: size is taken from size_i on the first beat, from the latch afterwards.
  always_comb begin
    accept   = val_i & ~clear_i;
    size_eff = (cnt_q == '0) ? size_i : size_q;
    case (size_eff)
      SIZE_04: last_idx = 7'd1;
      SIZE_08: last_idx = 7'd7;
      SIZE_16: last_idx = 7'd31;
      SIZE_32: last_idx = 7'd127;
      default: last_idx = 7'd127;
    endcase
    sub_end = (size_eff == SIZE_04) ? cnt_q[0] : (cnt_q[2:0] == 3'b111);
    blk_end = (cnt_q == last_idx);
  end

  // Next-state for the beat counter, size latch and Stage A.
  always_comb begin
    cnt_d       = cnt_q;
    size_d      = size_q;
    a_vld_d     = 1'b0;
    a_sum_d     = a_sum_q;
    a_sub_end_d = a_sub_end_q;
    a_blk_end_d = a_blk_end_q;
    a_half_d    = a_half_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d       = blk_end ? 7'd0 : cnt_q + 7'd1;
      a_vld_d     = 1'b1;
      a_sum_d     = beat_sum;
      a_sub_end_d = sub_end;
      a_blk_end_d = blk_end;
      a_half_d    = (size_eff == SIZE_04);
      if (cnt_q == '0) begin
        size_d = size_i;
      end
    end
  end

  // Stage B: sub-block and block accumulation with rounding normalisation.
  always_comb begin
    sub_sum    = sub_acc_q + SUB_W'(a_sum_q);
    sub_rnd    = a_half_q ? (({1'b0, sub_sum} + 1'b1) >> 1) : (({1'b0, sub_sum} + 2'd2) >> 2);
    sub_norm   = COST_WIDTH'(sub_rnd);
    blk_sum    = blk_acc_q + sub_norm;
    sub_acc_d  = sub_acc_q;
    blk_acc_d  = blk_acc_q;
    cost_val_d = 1'b0;
    cost_d     = cost_q;
    if (clear_i) begin
      sub_acc_d = '0;
      blk_acc_d = '0;
    end else if (a_vld_q) begin
      if (a_sub_end_q) begin
        sub_acc_d = '0;
        if (a_blk_end_q) begin
          blk_acc_d  = '0;
          cost_d     = blk_sum;
          cost_val_d = 1'b1;
        end else begin
          blk_acc_d = blk_sum;
        end
      end else begin
        sub_acc_d = sub_sum;
      end
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      size_q      <= '0;
      a_vld_q     <= 1'b0;
      a_sum_q     <= '0;
      a_sub_end_q <= 1'b0;
      a_blk_end_q <= 1'b0;
      a_half_q    <= 1'b0;
      sub_acc_q   <= '0;
      blk_acc_q   <= '0;
      cost_val_q  <= 1'b0;
      cost_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      a_vld_q     <= a_vld_d;
      a_sum_q     <= a_sum_d;
      a_sub_end_q <= a_sub_end_d;
      a_blk_end_q <= a_blk_end_d;
      a_half_q    <= a_half_d;
      sub_acc_q   <= sub_acc_d;
      blk_acc_q   <= blk_acc_d;
      cost_val_q  <= cost_val_d;
      cost_q      <= cost_d;
    end
  end

  assign cost_val_o = cost_val_q;
  assign cost_o     = cost_q;

endmodule

// File: doc/posi_satd_cost_accum.md
Name: posi_satd_cost_accum

Overview:
- Downstream of the 8-lane Hadamard engine in post-intra.
- Consumes fully transformed (row and column pass) Hadamard coefficients, 8 per beat.
- Takes absolute values, sums them per 4x4 or 8x8 sub-block, normalises each sub-block and accumulates to one SATD cost per block of 4x4, 8x8, 16x16 or 32x32.
- The cost goes to the post-intra mode decision.

Parameters:
- COEF_WIDTH, 15, signed width of one coefficient (9-bit residual plus two 3-stage Hadamard passes).
- COST_WIDTH, 24, unsigned width of cost_o.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- size_i  input  2  block size: `SIZE_04`, `SIZE_08`, `SIZE_16`, `SIZE_32`; sampled on a block's first beat only.
- clear_i  input  1  synchronous abort; discards the block in progress and any pending output.
- val_i  input  1  coefficient beat valid.
- dat_i  input  COEF_WIDTH*8  8 signed coefficients; lane 0 in the MSBs.
- cost_val_o  output  1  one-cycle pulse; cost_o is valid.
- cost_o  output  COST_WIDTH  SATD cost of the completed block.

Behaviour:
- Reset: every register is cleared asynchronously. cost_val_o=0, cost_o=0, beat counter=0, accumulators=0, pipeline valids=0. Reset mid-block discards that block.
- Beats per block: SIZE_04=2, SIZE_08=8, SIZE_16=32, SIZE_32=128.
- Sub-block: 2 beats (4x4) for SIZE_04; 8 beats (8x8) for all other sizes.
- Beat counter advances only on val_i. Gaps (val_i low) are allowed anywhere and freeze all state except the in-flight pipeline.
- size_i is latched when val_i=1 and counter=0. It is ignored for the rest of the block.
- Counter wraps to 0 after the last beat. The next beat then starts a new block with no idle cycle (back-to-back).
- Stage A (registered, the cycle after val_i):
  - beat_sum = sum of |c_k| for k=0..7.
  - |x| is computed as a COEF_WIDTH-bit unsigned value, so -2^(COEF_WIDTH-1) maps to 2^(COEF_WIDTH-1).
  - beat_sum width is COEF_WIDTH+3.
  - Stage A also registers flags: valid, sub_end (last beat of a sub-block) and blk_end (last beat of the block).
- Stage B (registered):
  - sub_acc += beat_sum.
  - On sub_end: s = sub_acc + beat_sum, and sub_acc returns to 0.
  - norm(s) = (s+1)>>1 for SIZE_04, else (s+2)>>2.
  - blk_acc += norm(s).
  - On blk_end: cost_o <= blk_acc + norm(s), cost_val_o <= 1, and blk_acc returns to 0.
- Latency: last beat accepted in cycle T gives cost_val_o=1 in cycle T+2, for exactly one cycle.
- cost_o holds its value until the next completed block.
- No overflow handling: the default widths hold the maximum 32x32 cost without overflow.
- clear_i=1:
  - Counter, sub_acc and blk_acc go to 0.
  - Stage A valid is cleared.
  - A cost_val_o pulse due in the next cycle is suppressed.
  - cost_o is unchanged.
  - A val_i beat in the same cycle is dropped.
  - clear_i has priority over val_i.
- Stage B updates sub_acc and blk_acc each cycle from Stage A. A Stage A beat arriving while Stage B closes the previous block goes into freshly zeroed accumulators, so there is no carry between blocks.
- No backpressure: the block always accepts val_i.

Test Plan:
- SIZE_04, 2 beats, all coefficients +3 -> sum 48, cost_o=24, cost_val_o high exactly 2 cycles after the 2nd beat.
- SIZE_08, 8 beats, all coefficients -1, with val_i gaps of 1-3 cycles inserted -> cost_o=(64+2)>>2=16, single pulse.
- SIZE_16, 32 beats, all coefficients +2 -> each 8x8 sums to 128, normalises to 32; cost_o=128.
- SIZE_04, lane 0 = -16384 and other lanes 0 on beat 0, beat 1 all 0 -> sum 16384, cost_o=8192 (no abs overflow).
- SIZE_08, clear_i at beat 5, then SIZE_04 with all coefficients +1 -> no pulse for the aborted block; the 4x4 gives cost_o=8.
- Two back-to-back SIZE_04 blocks (all +1, then all +2), size_i driven to SIZE_08 on the 2nd beat of each -> costs 8 then 16, two pulses 2 cycles apart; the mid-block size change is ignored.
- Assert rst during beat 4 of a SIZE_08 block, then release -> cost_val_o=0 and cost_o=0; the next SIZE_04 block with all +1 gives cost_o=8.
